i2c_slave: RTL and testbench

//  Bus-side target that consumes the transactions driven by i2c_master on io_sda/SCL.

---
 rtl/i2c_slave_pkg.sv | 21 ++
 rtl/i2c_slave_if.sv | 26 ++
 rtl/i2c_slave_bus_sync.sv | 49 ++++
 rtl/i2c_slave.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_slave.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_slave_pkg.sv
// Shared constants and state encoding for the I2C target.
package i2c_slave_pkg;

    localparam int ADDR_WIDTH = 7;
    localparam int DATA_SIZE  = 8;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WRITE     = 3'd3,
        ST_WRITE_ACK = 3'd4,
        ST_READ      = 3'd5,
        ST_READ_ACK  = 3'd6,
        ST_WAIT_STOP = 3'd7
    } slv_state_e;

endpackage

// File: rtl/i2c_slave_if.sv
// SCL input and user-side signals of the I2C target; SDA remains a separate inout pin.
interface i2c_slave_if;
    import i2c_slave_pkg::*;

    logic                 scl_i;
    logic                 rx_ack_i;
    logic [DATA_SIZE-1:0] tx_data_i;
    logic                 tx_req_o;
    logic [DATA_SIZE-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 busy_o;
    slv_state_e           state_o;

    // rx_valid_o / tx_req_o are one-cycle pulses with no back-pressure: rx_data_o holds the
    // byte from the pulse onward; tx_data_i must stay stable from tx_req_o to the next SCL fall.
    modport slave (
        input  scl_i, rx_ack_i, tx_data_i,
        output tx_req_o, rx_data_o, rx_valid_o, busy_o, state_o
    );

    modport master (
        output scl_i, rx_ack_i, tx_data_i,
        input  tx_req_o, rx_data_o, rx_valid_o, busy_o, state_o
    );

endinterface

// File: rtl/i2c_slave_bus_sync.sv
// SCL/SDA synchronisers plus SCL edge and START/STOP condition pulses.
module i2c_slave_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Reset to the idle-bus level so leaving reset never fakes an edge on a quiet bus.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        sda_o      = sda_s;
        scl_rise_o = scl_s & ~scl_prev_q;
        scl_fall_o = ~scl_s & scl_prev_q;
        start_o    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
        stop_o     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    end

endmodule

// File: rtl/i2c_slave.sv
// I2C target: 7-bit address match, bytes written to the user, read bytes fetched on request.
// Bus lines are oversampled on i_clk; no clock stretching, no general call.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] SLAVE_ADDR  = 7'h50,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    inout  wire        io_sda,
    i2c_slave_if.slave bus
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_SIZE - 1);

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic bus_start;
    logic bus_stop;

    slv_state_e           state_q,    state_d;
    logic [2:0]           bit_cnt_q,  bit_cnt_d;
    logic [DATA_SIZE-2:0] shift_q,    shift_d;
    logic [DATA_SIZE-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_SIZE-1:0] rx_data_q,  rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 tx_req_q,   tx_req_d;
    logic                 sda_low_q,  sda_low_d;
    logic                 phase_q,    phase_d;
    logic                 rw_q,       rw_d;
    logic                 ack_q,      ack_d;

    i2c_slave_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .scl_i      (bus.scl_i),
        .sda_i      (io_sda),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise),
        .scl_fall_o (scl_fall),
        .start_o    (bus_start),
        .stop_o     (bus_stop)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            sda_low_q  <= 1'b0;
            phase_q    <= 1'b0;
            rw_q       <= RW_WRITE;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_shift_q <= tx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            sda_low_q  <= sda_low_d;
            phase_q    <= phase_d;
            rw_q       <= rw_d;
            ack_q      <= ack_d;
        end
    end

    // phase_q marks the second half of an ACK slot: cleared at slot entry, set on the
    // SCL fall that opens the ACK bit, consumed on the fall that closes it.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        tx_shift_d = tx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        sda_low_d  = sda_low_q;
        phase_d    = phase_q;
        rw_d       = rw_q;
        ack_d      = ack_q;

        if (bus_stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            phase_d   = 1'b0;
        end else if (bus_start) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            phase_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DATA_SIZE-3:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            rw_d    = sda_s;
                            phase_d = 1'b0;
                            state_d = (shift_q == SLAVE_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d   = 1'b1;
                            sda_low_d = 1'b1;
                        end else begin
                            phase_d   = 1'b0;
                            bit_cnt_d = '0;
                            if (rw_q == RW_READ) begin
                                tx_shift_d = bus.tx_data_i;
                                sda_low_d  = ~bus.tx_data_i[DATA_SIZE-1];
                                state_d    = ST_READ;
                            end else begin
                                sda_low_d = 1'b0;
                                state_d   = ST_WRITE;
                            end
                        end
                    end else if (scl_rise && phase_q && (rw_q == RW_READ)) begin
                        tx_req_d = 1'b1;
                    end
                end

                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d   = {shift_q[DATA_SIZE-3:0], sda_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            rx_data_d  = {shift_q, sda_s};
                            rx_valid_d = 1'b1;
                            ack_d      = bus.rx_ack_i;
                            phase_d    = 1'b0;
                            state_d    = ST_WRITE_ACK;
                        end
                    end
                end

                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d   = 1'b1;
                            sda_low_d = ack_q;
                        end else begin
                            phase_d   = 1'b0;
                            sda_low_d = 1'b0;
                            state_d   = ack_q ? ST_WRITE : ST_WAIT_STOP;
                        end
                    end
                end

                ST_READ: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == LAST_BIT) begin
                            phase_d = 1'b0;
                            state_d = ST_READ_ACK;
                        end
                    end else if (scl_fall) begin
                        // Rotate rather than shift so every bit of the register stays live.
                        tx_shift_d = {tx_shift_q[DATA_SIZE-2:0], tx_shift_q[DATA_SIZE-1]};
                        sda_low_d  = ~tx_shift_q[DATA_SIZE-2];
                    end
                end

                ST_READ_ACK: begin
                    if (scl_fall && !phase_q) begin
                        sda_low_d = 1'b0;
                        phase_d   = 1'b1;
                    end else if (scl_rise && phase_q) begin
                        if (sda_s) begin
                            phase_d = 1'b0;
                            state_d = ST_WAIT_STOP;
                        end else begin
                            tx_req_d = 1'b1;
                        end
                    end else if (scl_fall && phase_q) begin
                        tx_shift_d = bus.tx_data_i;
                        sda_low_d  = ~bus.tx_data_i[DATA_SIZE-1];
                        bit_cnt_d  = '0;
                        phase_d    = 1'b0;
                        state_d    = ST_READ;
                    end
                end

                default: ;
            endcase
        end
    end

    always_comb begin
        bus.tx_req_o   = tx_req_q;
        bus.rx_data_o  = rx_data_q;
        bus.rx_valid_o = rx_valid_q;
        bus.busy_o     = (state_q != ST_IDLE);
        bus.state_o    = state_q;
    end

    // Open drain: only ever pull low or release.
    assign io_sda = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: table of write transactions plus hand-written read,
// NACK, repeated-START and mid-transfer reset sequences driven by a bit-banged master.
module tb_i2c_slave;
    import i2c_slave_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic m_low;
    wire  sda;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    i2c_slave_if bus_if ();

    i2c_slave #(
        .SLAVE_ADDR  (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_sda (sda),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr_b;
        logic [7:0] data_b;
        logic       rx_ack;
        logic       exp_aack;
        logic       exp_dack;
        slv_state_e exp_mid;
        slv_state_e exp_end;
        logic       exp_valid;
        logic       exp_drive;
    } wr_vec_t;

    wr_vec_t    vecs[6];
    logic [7:0] rd_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_rx;

    int   n_checks       = 0;
    int   n_pass         = 0;
    int   rx_valid_cnt   = 0;
    int   tx_req_cnt     = 0;
    logic slave_low_seen = 1'b0;
    logic both_seen      = 1'b0;
    logic busy_gap       = 1'b0;
    logic watch_busy     = 1'b0;

    // Bus monitor and read-byte provider, sampled on the falling clock edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.rx_valid_o) rx_valid_cnt++;
            if (bus_if.rx_valid_o && bus_if.tx_req_o) both_seen = 1'b1;
            if (!m_low && sda === 1'b0) slave_low_seen = 1'b1;
            if (watch_busy && !bus_if.busy_o) busy_gap = 1'b1;
            if (bus_if.tx_req_o) begin
                tx_req_cnt++;
                if (rd_q.size() > 0) bus_if.tx_data_i = rd_q.pop_front();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic q_wait();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        m_low = 1'b0;
        q_wait();
        bus_if.scl_i = 1'b1;
        q_wait();
        m_low = 1'b1;
        q_wait();
        bus_if.scl_i = 1'b0;
        q_wait();
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        q_wait();
        bus_if.scl_i = 1'b1;
        q_wait();
        m_low = 1'b0;
        q_wait();
        q_wait();
    endtask

    task automatic send_bit(input logic b);
        m_low = ~b;
        q_wait();
        bus_if.scl_i = 1'b1;
        q_wait();
        q_wait();
        bus_if.scl_i = 1'b0;
        q_wait();
    endtask

    task automatic recv_bit(output logic r);
        m_low = 1'b0;
        q_wait();
        bus_if.scl_i = 1'b1;
        q_wait();
        r = (sda !== 1'b0);
        q_wait();
        bus_if.scl_i = 1'b0;
        q_wait();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(r);
            b[i] = r;
        end
    endtask

    task automatic check_read_byte(input string name);
        logic [7:0] got;
        logic [7:0] want;
        recv_byte(got);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        check(name, 32'(got), 32'(want));
    endtask

    initial begin
        logic       a;
        logic       d;
        int         v0;
        int         t0;

        vecs[0] = '{8'hA0, 8'h3C, 1'b1, 1'b0, 1'b0, ST_WRITE,     ST_WRITE,     1'b1, 1'b1};
        vecs[1] = '{8'hA2, 8'hFF, 1'b1, 1'b1, 1'b1, ST_WAIT_STOP, ST_WAIT_STOP, 1'b0, 1'b0};
        vecs[2] = '{8'hA0, 8'h81, 1'b1, 1'b0, 1'b0, ST_WRITE,     ST_WRITE,     1'b1, 1'b1};
        vecs[3] = '{8'h20, 8'h00, 1'b1, 1'b1, 1'b1, ST_WAIT_STOP, ST_WAIT_STOP, 1'b0, 1'b0};
        vecs[4] = '{8'hA0, 8'h5A, 1'b0, 1'b0, 1'b1, ST_WRITE,     ST_WAIT_STOP, 1'b1, 1'b1};
        vecs[5] = '{8'h21, 8'hA5, 1'b1, 1'b1, 1'b1, ST_WAIT_STOP, ST_WAIT_STOP, 1'b0, 1'b0};

        rst              = 1'b1;
        m_low            = 1'b0;
        bus_if.scl_i     = 1'b1;
        bus_if.rx_ack_i  = 1'b1;
        bus_if.tx_data_i = 8'h00;
        exp_rx           = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        q_wait();

        check("reset state",    32'(bus_if.state_o),    32'(ST_IDLE));
        check("reset sda",      32'(sda),               32'(1'b1));
        check("reset rx_data",  32'(bus_if.rx_data_o),  32'h00);
        check("reset rx_valid", 32'(bus_if.rx_valid_o), 32'h0);
        check("reset tx_req",   32'(bus_if.tx_req_o),   32'h0);
        check("reset busy",     32'(bus_if.busy_o),     32'h0);

        // Single-byte write transactions from the table.
        for (int i = 0; i < 6; i++) begin
            slave_low_seen = 1'b0;
            v0 = rx_valid_cnt;
            bus_start();
            check($sformatf("v%0d busy after start", i), 32'(bus_if.busy_o), 32'h1);
            send_byte(vecs[i].addr_b);
            recv_bit(a);
            check($sformatf("v%0d addr ack", i), 32'(a), 32'(vecs[i].exp_aack));
            check($sformatf("v%0d state after addr", i), 32'(bus_if.state_o), 32'(vecs[i].exp_mid));
            bus_if.rx_ack_i = vecs[i].rx_ack;
            send_byte(vecs[i].data_b);
            recv_bit(d);
            check($sformatf("v%0d data ack", i), 32'(d), 32'(vecs[i].exp_dack));
            check($sformatf("v%0d state after data", i), 32'(bus_if.state_o), 32'(vecs[i].exp_end));
            bus_stop();
            if (vecs[i].exp_valid) exp_rx = vecs[i].data_b;
            check($sformatf("v%0d rx_valid pulses", i), 32'(rx_valid_cnt - v0), 32'(vecs[i].exp_valid));
            check($sformatf("v%0d rx_data", i), 32'(bus_if.rx_data_o), 32'(exp_rx));
            check($sformatf("v%0d slave drove sda", i), 32'(slave_low_seen), 32'(vecs[i].exp_drive));
            check($sformatf("v%0d busy after stop", i), 32'(bus_if.busy_o), 32'h0);
            check($sformatf("v%0d state after stop", i), 32'(bus_if.state_o), 32'(ST_IDLE));
        end
        bus_if.rx_ack_i = 1'b1;

        // Read of two bytes: master ACKs the first and NACKs the second.
        rd_q.push_back(8'h96);
        rd_q.push_back(8'h5A);
        exp_q.push_back(8'h96);
        exp_q.push_back(8'h5A);
        t0 = tx_req_cnt;
        bus_start();
        send_byte(8'hA1);
        recv_bit(a);
        check("rd addr ack", 32'(a), 32'h0);
        check("rd tx_req after addr", 32'(tx_req_cnt - t0), 32'h1);
        check("rd state", 32'(bus_if.state_o), 32'(ST_READ));
        check_read_byte("rd byte0");
        send_bit(1'b0);
        check_read_byte("rd byte1");
        send_bit(1'b1);
        check("rd state after nack", 32'(bus_if.state_o), 32'(ST_WAIT_STOP));
        check("rd sda released", 32'(sda), 32'h1);
        check("rd tx_req pulses", 32'(tx_req_cnt - t0), 32'h2);
        bus_stop();
        check("rd busy after stop", 32'(bus_if.busy_o), 32'h0);

        // NACK on the first data byte; the following byte must be ignored.
        bus_start();
        send_byte(8'hA0);
        recv_bit(a);
        check("nack addr ack", 32'(a), 32'h0);
        v0 = rx_valid_cnt;
        bus_if.rx_ack_i = 1'b0;
        send_byte(8'h77);
        recv_bit(d);
        bus_if.rx_ack_i = 1'b1;
        exp_rx = 8'h77;
        check("nack data slot", 32'(d), 32'h1);
        check("nack rx_data", 32'(bus_if.rx_data_o), 32'(exp_rx));
        send_byte(8'h12);
        recv_bit(d);
        check("nack next byte ack", 32'(d), 32'h1);
        check("nack rx_valid pulses", 32'(rx_valid_cnt - v0), 32'h1);
        check("nack rx_data kept", 32'(bus_if.rx_data_o), 32'(exp_rx));
        check("nack state", 32'(bus_if.state_o), 32'(ST_WAIT_STOP));
        bus_stop();

        // Write 0x11 then repeated START into a read; busy must never drop.
        rd_q.push_back(8'hC3);
        exp_q.push_back(8'hC3);
        busy_gap = 1'b0;
        bus_start();
        watch_busy = 1'b1;
        send_byte(8'hA0);
        recv_bit(a);
        check("rs addr ack", 32'(a), 32'h0);
        send_byte(8'h11);
        recv_bit(d);
        exp_rx = 8'h11;
        check("rs data ack", 32'(d), 32'h0);
        bus_start();
        check("rs state after restart", 32'(bus_if.state_o), 32'(ST_ADDR));
        check("rs rx_data", 32'(bus_if.rx_data_o), 32'(exp_rx));
        send_byte(8'hA1);
        recv_bit(a);
        check("rs read addr ack", 32'(a), 32'h0);
        check_read_byte("rs read byte");
        send_bit(1'b1);
        watch_busy = 1'b0;
        bus_stop();
        check("rs busy gap", 32'(busy_gap), 32'h0);
        check("rs busy after stop", 32'(bus_if.busy_o), 32'h0);

        // Reset while the slave pulls SDA low for a 0 read bit.
        rd_q.push_back(8'h00);
        bus_start();
        send_byte(8'hA1);
        recv_bit(a);
        check("rst addr ack", 32'(a), 32'h0);
        check("rst slave drives 0", 32'(sda === 1'b0), 32'h1);
        bus_if.scl_i = 1'b1;
        q_wait();
        rst = 1'b1;
        #2;
        exp_rx = 8'h00;
        check("rst sda released", 32'(sda), 32'h1);
        check("rst state", 32'(bus_if.state_o), 32'(ST_IDLE));
        check("rst rx_data", 32'(bus_if.rx_data_o), 32'(exp_rx));
        check("rst busy", 32'(bus_if.busy_o), 32'h0);
        check("rst tx_req", 32'(bus_if.tx_req_o), 32'h0);
        check("rst rx_valid", 32'(bus_if.rx_valid_o), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus_if.scl_i = 1'b0;
        q_wait();
        send_bit(1'b1);
        send_bit(1'b0);
        check("rst ignores bus", 32'(bus_if.state_o), 32'(ST_IDLE));
        bus_start();
        send_byte(8'hA0);
        recv_bit(a);
        check("post-rst addr ack", 32'(a), 32'h0);
        send_byte(8'h42);
        recv_bit(d);
        exp_rx = 8'h42;
        check("post-rst data ack", 32'(d), 32'h0);
        bus_stop();
        check("post-rst rx_data", 32'(bus_if.rx_data_o), 32'(exp_rx));
        check("rx_valid/tx_req overlap", 32'(both_seen), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
